memristor_infra_multiplier_4bit: RTL and testbench
==================================================

# memristor_infra_multiplier_4bit

Sequential 4-bit signed (two's complement) multiplier producing a full 8-bit signed product. It is the arithmetic core of the memristor infrastructure datapath: a radix-2 Booth engine that reuses one add/subtract unit over four iteration cycles instead of a combinational array. Operands are captured on a start request and the product is held with a level `done` flag until the requester withdraws `start`.

## Interface
- No parameters; operand width is fixed at 4 bits and product width at 8 bits.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-low reset. Sampled on `clk` rising edge; `rst`=0 forces reset state.
- `start` input 1: level request; sampled only in IDLE.
- `multiplier` input 4: signed operand Q, captured on the accepting edge.
- `multiplicand` input 4: signed operand M, captured on the accepting edge.
- `result` output 8: signed product `multiplier*multiplicand`, registered.
- `done` output 1: registered; high while `result` holds a valid product.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE: `done`=0. If `start`=1, load A (5-bit accumulator)=0, Q=`multiplier`, Q₋₁=0, M=`multiplicand` sign-extended to 5 bits, count=4, go to CALC. Otherwise stay.
- CALC, one Booth step per cycle on bit pair {Q[0],Q₋₁}:
  - 01: A = A + M; 10: A = A − M; 00/11: no add.
  - Then arithmetic right shift of {A,Q,Q₋₁} by one (A MSB replicated).
  - Decrement count; after the 4th step go to DONE and register `result` = {A[3:0],Q}.
- DONE: `done`=1, `result` held stable. Stay while `start`=1; on `start`=0 return to IDLE (`done` drops; `result` keeps last product).
- 5-bit accumulator required so that A − M with M = −8 does not overflow; every 4×4 signed product (−56…+64) is exact in 8 bits.
- Operand inputs are ignored outside the IDLE accept edge; changes during CALC/DONE do not affect the product.
- A new operation requires `start` low for at least one cycle in IDLE-return (or a reset), then high again.

## Timing
- Reset (`rst`=0 at a rising edge): state=IDLE, `result`=8'h00, `done`=0, all internal registers cleared. Takes priority over every other condition, including mid-CALC or DONE; the operation in flight is abandoned.
- Latency: edge E0 accepts `start` (IDLE→CALC); edges E1–E4 perform the four Booth steps; `result` and `done`=1 are visible after E4 (4 cycles after the accepting edge, 5 edges from first sampling of `start` counted inclusively).
- `done` stays high every cycle `start` remains high; falls the cycle after the edge that samples `start`=0 in DONE.
- `start` dropping during CALC does not abort; the product completes, DONE is entered, and the FSM returns to IDLE on the next edge.
- `start` held high continuously after reset release immediately begins an operation on the first edge with `rst`=1.

## Test plan
- Reset: hold `rst`=0 several cycles with `start`=1 -> `result`=0, `done`=0; release with Q=3, M=7, `start`=1 -> `done`=1 after 4 cycles, `result`=21.
- Negative×positive: reset, Q=−3 (4'b1101), M=5, `start`=1 -> `result`=−15 (8'hF1), `done`=1.
- Negative×negative: reset, Q=−7, M=−7 -> `result`=49; corner Q=−8, M=−8 -> `result`=64; Q=−8, M=7 -> `result`=−56.
- Hold/handshake: keep `start`=1 10 cycles after `done` -> `result` stable, `done` high; drop `start` -> `done`=0 next cycle, `result` unchanged; raise `start` with new operands (2×−4) -> `result`=−8.
- Operand change mid-calc: change Q/M during CALC -> product reflects values captured at accept edge.
- Reset mid-operation: assert `rst`=0 during CALC -> `done`=0, `result`=0 next edge; no stale `done` afterward.

Source files
------------

// File: rtl/memristor_infra_multiplier_4bit.sv
// Sequential 4x4 signed radix-2 Booth multiplier. One shared add/subtract unit is used
// over four iteration cycles, and the 8-bit product is held with a level done flag.
module memristor_infra_multiplier_4bit (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] multiplier,
  input  logic [3:0] multiplicand,
  output logic [7:0] result,
  output logic       done
);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  state_e     state_q;
  logic [4:0] acc_q;
  logic [4:0] m_q;
  logic [3:0] q_q;
  logic       qm1_q;
  logic [2:0] count_q;
  logic [7:0] result_q;
  logic       done_q;

  logic [4:0] acc_sum;
  logic [4:0] acc_next;
  logic [3:0] q_next;

  // One Booth step: a conditional add/subtract, then an arithmetic shift of {A,Q,Q-1}.
  // A is 5 bits wide so that subtracting M = -8 cannot overflow.
  always_comb begin
    acc_sum = acc_q;
    case ({q_q[0], qm1_q})
      2'b01:   acc_sum = acc_q + m_q;
      2'b10:   acc_sum = acc_q - m_q;
      default: acc_sum = acc_q;
    endcase
    acc_next = {acc_sum[4], acc_sum[4:1]};
    q_next   = {acc_sum[0], q_q[3:1]};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      m_q      <= '0;
      q_q      <= '0;
      qm1_q    <= 1'b0;
      count_q  <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (start) begin
            acc_q   <= '0;
            q_q     <= multiplier;
            qm1_q   <= 1'b0;
            m_q     <= {multiplicand[3], multiplicand};
            count_q <= 3'd4;
            state_q <= StCalc;
          end
        end
        StCalc: begin
          acc_q   <= acc_next;
          q_q     <= q_next;
          qm1_q   <= q_q[0];
          count_q <= count_q - 3'd1;
          if (count_q == 3'd1) begin
            result_q <= {acc_next[3:0], q_next};
            done_q   <= 1'b1;
            state_q  <= StDone;
          end
        end
        StDone: begin
          // result stays put after done drops; only a new product or reset changes it
          if (!start) begin
            done_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign result = result_q;
  assign done   = done_q;

endmodule

// File: tb/tb_memristor_infra_multiplier_4bit.sv
// Self-checking bench for memristor_infra_multiplier_4bit: expected products are queued
// when an operation is accepted and compared when done rises.
module tb_memristor_infra_multiplier_4bit;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] multiplier;
  logic [3:0] multiplicand;
  logic [7:0] result;
  logic       done;

  int n_checks;
  int n_pass;
  logic [7:0] exp_q[$];

  memristor_infra_multiplier_4bit dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplier   (multiplier),
    .multiplicand (multiplicand),
    .result       (result),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_prod(input logic [3:0] a, input logic [3:0] b);
    int ai;
    int bi;
    ai = $signed(a);
    bi = $signed(b);
    return 8'(ai * bi);
  endfunction

  // Called just after a negedge; waits for done and returns negedges elapsed.
  task automatic wait_done(input int cyc_in, output int cyc_out);
    int cyc;
    cyc = cyc_in;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < 20);
    cyc_out = cyc;
  endtask

  task automatic pop_compare(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq(tag, {24'd0, result}, {24'd0, e});
    end
  endtask

  // Full operation with start held `hold` cycles after done, then handshake drop.
  task automatic do_op(input logic [3:0] a, input logic [3:0] b, input int hold,
                       input string tag);
    int cyc;
    logic [7:0] held;
    multiplier   = a;
    multiplicand = b;
    start        = 1'b1;
    exp_q.push_back(model_prod(a, b));
    wait_done(0, cyc);
    check_eq({tag, "_latency"}, cyc, 32'd5);
    check_eq({tag, "_done"}, {31'd0, done}, 32'd1);
    pop_compare({tag, "_result"});
    held = result;
    for (int i = 0; i < hold; i++) begin
      multiplier   = 4'($urandom);
      multiplicand = 4'($urandom);
      @(negedge clk);
      check_eq({tag, "_hold_done"}, {31'd0, done}, 32'd1);
      check_eq({tag, "_hold_result"}, {24'd0, result}, {24'd0, held});
    end
    start = 1'b0;
    @(negedge clk);
    check_eq({tag, "_drop_done"}, {31'd0, done}, 32'd0);
    check_eq({tag, "_drop_result"}, {24'd0, result}, {24'd0, held});
  endtask

  initial begin
    int cyc;
    n_checks = 0;
    n_pass   = 0;
    rst          = 1'b0;
    start        = 1'b1;
    multiplier   = 4'd3;
    multiplicand = 4'd7;
    repeat (3) @(negedge clk);
    check_eq("reset_result", {24'd0, result}, 32'd0);
    check_eq("reset_done", {31'd0, done}, 32'd0);

    // start already high at release: first edge with rst=1 accepts
    rst = 1'b1;
    do_op(4'd3, 4'd7, 0, "p3x7");
    check_eq("p3x7_value", {24'd0, result}, 32'd21);

    do_op(4'b1101, 4'd5, 0, "n3x5");
    check_eq("n3x5_value", {24'd0, result}, 32'hF1);
    do_op(4'b1001, 4'b1001, 0, "n7xn7");
    check_eq("n7xn7_value", {24'd0, result}, 32'd49);
    do_op(4'b1000, 4'b1000, 0, "n8xn8");
    check_eq("n8xn8_value", {24'd0, result}, 32'd64);
    do_op(4'b1000, 4'd7, 0, "n8x7");
    check_eq("n8x7_value", {24'd0, result}, 32'hC8);

    // hold start high after done, then a new request
    do_op(4'd6, 4'b1011, 10, "hold");
    do_op(4'd2, 4'b1100, 0, "p2xn4");
    check_eq("p2xn4_value", {24'd0, result}, 32'hF8);

    // operand change and start drop during CALC
    multiplier   = 4'd5;
    multiplicand = 4'b1101;
    start        = 1'b1;
    exp_q.push_back(model_prod(4'd5, 4'b1101));
    @(negedge clk);
    multiplier   = 4'd7;
    multiplicand = 4'd7;
    start        = 1'b0;
    wait_done(1, cyc);
    check_eq("midchg_latency", cyc, 32'd5);
    pop_compare("midchg_result");
    check_eq("midchg_value", {24'd0, result}, 32'hF1);
    @(negedge clk);
    check_eq("midchg_autoidle_done", {31'd0, done}, 32'd0);

    // reset mid-operation
    multiplier   = 4'd5;
    multiplicand = 4'd5;
    start        = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("midrst_done", {31'd0, done}, 32'd0);
    check_eq("midrst_result", {24'd0, result}, 32'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("midrst_no_stale_done", {31'd0, done}, 32'd0);
    end

    for (int i = 0; i < 8; i++) begin
      do_op(4'($urandom), 4'($urandom), i % 3, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
